// File: rtl/uart_tx_arbiter_pkg.sv
// uart_defs: shared types and constants for the UART TX arbiter slice.
//   ArbState_t       - arbiter FSM states (IDLE, XFER, GUARD)
//   UART_ARB_MAX_REQ - largest supported requester count
//   UART_ARB_CNT_W   - width of the per-grant beat counter
//   arb_oh2idx()     - one-hot (up to UART_ARB_MAX_REQ bits) to index
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    GUARD = 2'd2
  } ArbState_t;

  localparam int unsigned UART_ARB_MAX_REQ = 8;
  localparam int unsigned UART_ARB_CNT_W   = 8;
  localparam int unsigned UART_ARB_IDX_W   = $clog2(UART_ARB_MAX_REQ);

  function automatic logic [UART_ARB_IDX_W-1:0] arb_oh2idx(
    input logic [UART_ARB_MAX_REQ-1:0] oh
  );
    logic [UART_ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < UART_ARB_MAX_REQ; i++) begin
      if (oh[i]) idx = UART_ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
//   req        - request vector, one bit per requester
//   ptr        - index that currently holds the highest priority
//   gnt_onehot - first set request at or above ptr, wrapping modulo N_REQ
//   any        - at least one request is set
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt_onehot,
  output logic                     any
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        gnt_onehot[idx] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART TX datapath
// between N_REQ byte-stream requesters, gated by the flow controller's enable.
//   tck, rst      - clock, synchronous active-high reset
//   req_valid_i   - per-requester beat valid
//   req_data_i    - per-requester byte
//   req_last_i    - final beat of a requester's message
//   req_ready_o   - per-requester beat accepted
//   tx_data_o     - byte to TX core (held while tx_rts_n_o is high)
//   tx_rts_n_o    - active-low request to TX core
//   tx_cts_n_i    - active-low accept from TX core
//   tx_enable_i   - TX enable from flow controller
//   grant_o       - one-hot current grant (registered)
//   busy_o        - high in XFER or GUARD
// Build option UART_TX_ARB_PRIO_EN: requester 0 becomes strict priority and
// its grants leave the round-robin pointer untouched.
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                          tck,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data_i,
  input  logic [N_REQ-1:0]              req_last_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [DATA_W-1:0]             tx_data_o,
  output logic                          tx_rts_n_o,
  input  logic                          tx_cts_n_i,
  input  logic                          tx_enable_i,
  output logic [N_REQ-1:0]              grant_o,
  output logic                          busy_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam logic [3:0] GUARD_LAST =
    (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);
  localparam logic [UART_ARB_CNT_W-1:0] BEAT_LAST =
    UART_ARB_CNT_W'(MAX_BURST - 1);

  ArbState_t                 state_q, state_d;
  logic [N_REQ-1:0]          grant_q, grant_d;
  logic [PTR_W-1:0]          gidx_q, gidx_d;
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [UART_ARB_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [3:0]                guard_cnt_q, guard_cnt_d;
  logic [DATA_W-1:0]         data_q;

  logic [N_REQ-1:0]            pick_gnt, sel_gnt;
  logic                        pick_any;
  logic [UART_ARB_MAX_REQ-1:0] sel_wide;
  logic [PTR_W-1:0]            sel_idx;
  logic [PTR_W-1:0]            ptr_after;
  logic                        beat, burst_end;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req_valid_i),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_gnt),
    .any        (pick_any)
  );

  // Winner selection; the priority build overrides the round-robin result.
  always_comb begin
`ifdef UART_TX_ARB_PRIO_EN
    sel_gnt = req_valid_i[0] ? {{(N_REQ-1){1'b0}}, 1'b1} : pick_gnt;
`else
    sel_gnt = pick_gnt;
`endif
    sel_wide              = '0;
    sel_wide[N_REQ-1:0]   = sel_gnt;
    sel_idx               = PTR_W'(arb_oh2idx(sel_wide));
  end

  // Pointer after a finished burst: the finisher drops to lowest priority.
  always_comb begin
    ptr_after = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
`ifdef UART_TX_ARB_PRIO_EN
    if (gidx_q == '0) ptr_after = rr_ptr_q;
`endif
  end

  // Datapath outputs: combinational from the held grant while in XFER.
  // tx_data_o otherwise replays the last driven byte from data_q.
  always_comb begin
    tx_rts_n_o  = 1'b1;
    req_ready_o = '0;
    tx_data_o   = data_q;
    beat        = 1'b0;
    case (state_q)
      XFER: begin
        tx_rts_n_o          = ~(req_valid_i[gidx_q] & tx_enable_i);
        req_ready_o[gidx_q] = ~tx_cts_n_i & tx_enable_i;
        if (req_valid_i[gidx_q] & tx_enable_i) tx_data_o = req_data_i[gidx_q];
        beat = req_valid_i[gidx_q] & tx_enable_i & ~tx_cts_n_i;
      end
      IDLE, GUARD: begin
      end
      default: tx_data_o = '0;
    endcase
  end

  assign burst_end = beat & (req_last_i[gidx_q] | (beat_cnt_q == BEAT_LAST));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      IDLE: begin
        if (tx_enable_i && pick_any) begin
          state_d    = XFER;
          grant_d    = sel_gnt;
          gidx_d     = sel_idx;
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        if (beat) beat_cnt_d = beat_cnt_q + UART_ARB_CNT_W'(1);
        if (burst_end) begin
          rr_ptr_d    = ptr_after;
          grant_d     = '0;
          guard_cnt_d = '0;
          state_d     = (GUARD_CYCLES == 0) ? IDLE : GUARD;
        end
      end
      GUARD: begin
        if (guard_cnt_q == GUARD_LAST) state_d = IDLE;
        else guard_cnt_d = guard_cnt_q + 4'd1;
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        gidx_d      = '0;
        rr_ptr_d    = '0;
        beat_cnt_d  = '0;
        guard_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      guard_cnt_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      data_q      <= tx_data_o;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == XFER) || (state_q == GUARD);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=16,
// GUARD_CYCLES=2). Honours UART_TX_ARB_PRIO_EN when defined.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int GC = 2;

  logic                 tck = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [N-1:0][DW-1:0] req_data_i;
  logic [DW-1:0]        tx_data_o;
  logic                 tx_rts_n_o, tx_cts_n_i, tx_enable_i, busy_o;

  always #5 tck = ~tck;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .GUARD_CYCLES(GC)) dut (
    .tck(tck), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .tx_data_o(tx_data_o), .tx_rts_n_o(tx_rts_n_o),
    .tx_cts_n_i(tx_cts_n_i), .tx_enable_i(tx_enable_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus sources: each requester streams bytes byte_of(i, seq).
  int  seq[N], rem[N], msgs_left[N], msg_len[N];
  bit  acc[N];
  bit  rand_len = 0, en_val = 1, en_rand = 0, rst_val = 1;
  int  drop_pct = 0, cts_mode = 0, rst_pm = 0;

  // Reference model state.
  int            m_owner = -1, m_guard = 0, m_rr = 0, m_beats = 0;
  logic [DW-1:0] m_last = '0;
  int            recv[N];

  // Observations of the DUT used by the literal checks.
  int           dut_acc = 0, gap_run = 0, cur_beats = 0;
  int           grant_log[$], burst_log[$], gap_log[$];
  logic [N-1:0] prev_grant = '0;

  function automatic logic [7:0] byte_of(int i, int s);
    return 8'(i * 67 + s * 13 + 5);
  endfunction

  function automatic int oh_idx(logic [N-1:0] oh);
    int r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Compare process: model outputs vs DUT on every cycle, then advance model.
  always @(negedge tck) begin
    logic [N-1:0]  e_grant, e_ready;
    logic          e_rts_n, e_busy;
    logic [DW-1:0] e_data;
    bit            beat;
    int            w;
    e_grant = '0; e_ready = '0; e_rts_n = 1'b1; e_data = m_last; beat = 0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_rts_n = !(req_valid_i[m_owner] && tx_enable_i);
      if (!tx_cts_n_i && tx_enable_i) e_ready[m_owner] = 1'b1;
      if (!e_rts_n) e_data = req_data_i[m_owner];
      beat = !e_rts_n && !tx_cts_n_i;
    end
    e_busy = (m_owner >= 0) || (m_guard > 0);
    chk("grant", 32'(grant_o), 32'(e_grant));
    chk("ready", 32'(req_ready_o), 32'(e_ready));
    chk("rts_n", 32'(tx_rts_n_o), 32'(e_rts_n));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("data", 32'(tx_data_o), 32'(e_data));
    if (beat && !rst) begin
      chk("order", 32'(tx_data_o), 32'(byte_of(m_owner, recv[m_owner])));
      recv[m_owner]++;
    end
    for (int i = 0; i < N; i++) acc[i] = !rst && req_valid_i[i] && e_ready[i];

    if (!rst) dut_acc += $countones(req_valid_i & req_ready_o);
    if (grant_o != '0 && prev_grant == '0) begin
      grant_log.push_back(oh_idx(grant_o));
      gap_log.push_back(gap_run);
      cur_beats = 0;
    end
    if (grant_o == '0) gap_run++; else gap_run = 0;
    if (!rst && |(req_valid_i & req_ready_o & grant_o)) cur_beats++;
    if (grant_o == '0 && prev_grant != '0) burst_log.push_back(cur_beats);
    prev_grant = grant_o;

    if (rst) begin
      m_owner = -1; m_guard = 0; m_rr = 0; m_beats = 0; m_last = '0;
    end else begin
      m_last = e_data;
      if (m_owner >= 0) begin
        if (beat) begin
          m_beats++;
          if (req_last_i[m_owner] || m_beats == MB) begin
`ifdef UART_TX_ARB_PRIO_EN
            if (m_owner != 0) m_rr = (m_owner + 1) % N;
`else
            m_rr = (m_owner + 1) % N;
`endif
            m_owner = -1;
            m_guard = GC;
          end
        end
      end else if (m_guard > 0) begin
        m_guard--;
      end else if (tx_enable_i && req_valid_i != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid_i[(m_rr + k) % N]) w = (m_rr + k) % N;
`ifdef UART_TX_ARB_PRIO_EN
        if (req_valid_i[0]) w = 0;
`endif
        m_owner = w;
        m_beats = 0;
      end
    end
  end

  // One clock of stimulus; returns just after the following negedge.
  task automatic drive_cycle();
    @(posedge tck); #1;
    rst = rst_val || (rst_pm > 0 && int'($urandom_range(999)) < rst_pm);
    tx_enable_i = en_rand ? ($urandom_range(9) != 0) : en_val;
    case (cts_mode)
      0:       tx_cts_n_i = 1'b0;
      1:       tx_cts_n_i = ~tx_cts_n_i;
      default: tx_cts_n_i = ($urandom_range(2) == 0);
    endcase
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
      end
      if (rem[i] == 0 && msgs_left[i] > 0) begin
        msgs_left[i]--;
        rem[i] = rand_len ? int'($urandom_range(20, 1)) : msg_len[i];
      end
      if (rem[i] != 0) begin
        req_valid_i[i] = int'($urandom_range(99)) >= drop_pct;
        req_data_i[i]  = byte_of(i, seq[i]);
        req_last_i[i]  = (rem[i] == 1);
      end else begin
        req_valid_i[i] = 1'b0;
        req_data_i[i]  = 8'($urandom);
        req_last_i[i]  = 1'($urandom_range(1));
      end
    end
    @(negedge tck); #1;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; msgs_left[i] = 0;
    end
    rst_val = 1; drive_cycle(); rst_val = 0;
    grant_log.delete(); burst_log.delete(); gap_log.delete();
    gap_run = 0;
  endtask

  initial begin
    int base;
    int exp_order[4];
    rst = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0;
    tx_cts_n_i = 1'b0; tx_enable_i = 1'b1;
    drive_cycle(); drive_cycle(); rst_val = 0;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_rts_n", 32'(tx_rts_n_o), 1);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_data", 32'(tx_data_o), 0);

    // Single requester, 3-beat message.
    msg_len[1] = 3; msgs_left[1] = 1; base = dut_acc;
    drive_cycle();
    chk("s1_no_grant_yet", 32'(grant_o), 0);
    drive_cycle();
    chk("s1_grant", 32'(grant_o), 32'h2);
    chk("s1_busy", 32'(busy_o), 1);
    repeat (3) drive_cycle();
    chk("s1_guard_grant", 32'(grant_o), 0);
    chk("s1_guard_busy", 32'(busy_o), 1);
    drive_cycle();
    chk("s1_guard2_busy", 32'(busy_o), 1);
    drive_cycle();
    chk("s1_busy_low", 32'(busy_o), 0);
    chk("s1_beats", 32'(dut_acc - base), 3);

    // All four streaming forever: forced rotation every MAX_BURST beats.
    reset_dut();
    for (int i = 0; i < N; i++) begin msg_len[i] = -1; msgs_left[i] = 1; end
    repeat (100) drive_cycle();
    chk("s2_ngrants", 32'(grant_log.size() >= 5), 1);
    exp_order = '{0, 1, 2, 3};
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      chk("s2_order", 32'(grant_log[k]), 32'(exp_order[k % 4]));
    for (int k = 0; k < 4 && k < burst_log.size(); k++)
      chk("s2_burst_len", 32'(burst_log[k]), 16);
    for (int k = 1; k < 5 && k < gap_log.size(); k++)
      chk("s2_gap", 32'(gap_log[k]), 3);

    // cts_n toggling during a 5-beat burst from req2.
    reset_dut();
    cts_mode = 1; msg_len[2] = 5; msgs_left[2] = 1; base = dut_acc;
    repeat (30) drive_cycle();
    chk("s3_beats", 32'(dut_acc - base), 5);
    chk("s3_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 2);
    cts_mode = 0;

    // Enable drop for 10 cycles after beat 4 of 8 from req3.
    reset_dut();
    msg_len[3] = 8; msgs_left[3] = 1; base = dut_acc;
    for (int k = 0; k < 40 && dut_acc - base < 4; k++) drive_cycle();
    chk("s4_first4", 32'(dut_acc - base), 4);
    en_val = 0;
    repeat (10) begin
      drive_cycle();
      chk("s4_hold_grant", 32'(grant_o), 32'h8);
      chk("s4_hold_rts_n", 32'(tx_rts_n_o), 1);
      chk("s4_hold_ready", 32'(req_ready_o), 0);
    end
    chk("s4_hold_cnt", 32'(dut_acc - base), 4);
    en_val = 1;
    repeat (20) drive_cycle();
    chk("s4_total", 32'(dut_acc - base), 8);
    chk("s4_one_burst", 32'(burst_log.size() > 0 ? burst_log[0] : -1), 8);

    // Reset on beat 7 of req1 after req2 has moved the pointer to 3.
    reset_dut();
    msg_len[2] = 2; msgs_left[2] = 1;
    repeat (8) drive_cycle();
    msg_len[1] = 10; msgs_left[1] = 1; base = dut_acc;
    for (int k = 0; k < 40 && dut_acc - base < 6; k++) drive_cycle();
    chk("s5_six", 32'(dut_acc - base), 6);
    msg_len[3] = 4; msgs_left[3] = 1;
    rst_val = 1; drive_cycle(); rst_val = 0;
    drive_cycle();
    chk("s5_rst_grant", 32'(grant_o), 0);
    chk("s5_rst_busy", 32'(busy_o), 0);
    chk("s5_rst_rts_n", 32'(tx_rts_n_o), 1);
    chk("s5_rst_ready", 32'(req_ready_o), 0);
    chk("s5_rst_data", 32'(tx_data_o), 0);
    drive_cycle();
    chk("s5_rearb", 32'(grant_o), 32'h2);
    repeat (40) drive_cycle();

    // req0 and req2 both streaming 2-beat messages.
    reset_dut();
    msg_len[0] = 2; msg_len[2] = 2; msgs_left[0] = 100; msgs_left[2] = 100;
    repeat (40) drive_cycle();
`ifdef UART_TX_ARB_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 2, 0, 2};
`endif
    chk("s6_ngrants", 32'(grant_log.size() >= 4), 1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("s6_order", 32'(grant_log[k]), 32'(exp_order[k]));

    // Randomised soak: drops, cts jitter, enable jitter, sporadic reset.
    reset_dut();
    rand_len = 1; drop_pct = 20; cts_mode = 2; en_rand = 1; rst_pm = 3;
    for (int i = 0; i < N; i++) msgs_left[i] = 1000;
    base = dut_acc;
    repeat (3000) drive_cycle();
    chk("soak_progress", 32'(dut_acc - base > 500), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
